sc_bus_ctrl: RTL and testbench

- Registered single-master, multi-slave system-bus controller for the RV32I single-cycle MCU.
- Generalises the fixed three-target combinational address decoder into a sequenced interconnect. It supports:
  - NUM_SLAVES parametrised base/mask regions.
  - A per-slave request/ready handshake, so slaves may insert wait states.
  - A timeout watchdog.
  - An explicit error response for unmapped or unresponsive accesses.
- Sits between the core's load/store unit and the memory, LED-bank and TTY peripherals.

---
 rtl/sc_bus_ctrl_pkg.sv | 29 ++
 rtl/sc_bus_ctrl_if.sv | 53 +++++
 rtl/sc_bus_ctrl_decode.sv | 33 +++
 rtl/sc_bus_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sc_bus_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sc_bus_pkg
// Shared types and default memory map for the single-master system bus
// controller (sc_bus_ctrl) and its address decoder (sc_bus_decode).
//   bus_state_e     : controller FSM states
//   MEM/LB/TTY_*    : default base/mask of the memory, LED bank and TTY
//   DEF_SLV_BASE/MASK : the three regions packed, index 0 in the LSBs
// ---------------------------------------------------------------------------
package sc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam int DEF_NUM_SLAVES = 3;

  localparam logic [31:0] MEM_BASE = 32'h0000_0000;
  localparam logic [31:0] MEM_MASK = 32'hFF00_0000;
  localparam logic [31:0] LB_BASE  = 32'hFF00_0000;
  localparam logic [31:0] LB_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] TTY_BASE = 32'hFF00_0004;
  localparam logic [31:0] TTY_MASK = 32'hFFFF_FFFC;

  localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLV_BASE = {TTY_BASE, LB_BASE, MEM_BASE};
  localparam logic [DEF_NUM_SLAVES*32-1:0] DEF_SLV_MASK = {TTY_MASK, LB_MASK, MEM_MASK};

endpackage

// File: rtl/sc_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// sc_bus_ctrl_if
// Bundles the core-side request/response signals and the shared slave-side
// bus. Signal names keep the controller's point of view (_i = into the
// controller, _o = out of it).
//   modport master : the load/store unit driving requests
//   modport slave  : the controller (slave of the master, driver of slaves)
//   modport periph : the slave peripherals (memory, LED bank, TTY)
// ---------------------------------------------------------------------------
interface sc_bus_ctrl_if
  import sc_bus_pkg::*;
#(
  parameter int NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);

  logic                         m_req_i;
  logic                         m_we_i;
  logic [DATA_W/8-1:0]          m_be_i;
  logic [ADDR_W-1:0]            m_addr_i;
  logic [DATA_W-1:0]            m_wdata_i;
  logic                         m_gnt_o;
  logic                         m_rvalid_o;
  logic [DATA_W-1:0]            m_rdata_o;
  logic                         m_err_o;

  logic [NUM_SLAVES-1:0]        slv_req_o;
  logic                         slv_we_o;
  logic [DATA_W/8-1:0]          slv_be_o;
  logic [ADDR_W-1:0]            slv_addr_o;
  logic [DATA_W-1:0]            slv_wdata_o;
  logic [NUM_SLAVES-1:0]        slv_ready_i;
  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata_i;

  modport master (
    output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o
  );

  modport slave (
    input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
    output slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o,
    input  slv_ready_i, slv_rdata_i
  );

  modport periph (
    input  slv_req_o, slv_we_o, slv_be_o, slv_addr_o, slv_wdata_o,
    output slv_ready_i, slv_rdata_i
  );

endinterface

// File: rtl/sc_bus_ctrl_decode.sv
// ---------------------------------------------------------------------------
// sc_bus_decode
// Combinational base/mask address match. Region i hits when
// (addr & mask[i]) == base[i]; on overlap the lowest index wins.
//   addr_i : byte address to decode
//   sel_o  : one-hot select of the winning region (0 when unmapped)
//   hit_o  : 1 when any region matched
// ---------------------------------------------------------------------------
module sc_bus_decode #(
  parameter int                           NUM_SLAVES = 3,
  parameter int                           ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = '0
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  hit_o
);

  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    // Ascending scan; once a region has hit, later (higher) ones are masked.
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_o &&
          ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// sc_bus_ctrl
// Registered single-master, multi-slave bus controller. Accepts one request
// at a time, forwards it to the decoded slave, waits for that slave's ready
// (bounded by a timeout watchdog) and returns a one-cycle response strobe.
// Unmapped and timed-out accesses complete with m_err_o = 1, rdata = 0.
//   clk_i   : system clock
//   rst_n_i : synchronous active-low reset
//   bus     : core request/response and shared slave bus (sc_bus_ctrl_if)
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | waiting for m_req_i; grant, latch request, decode
//   ST_ACCESS | slv_req_o[sel] asserted, counting cycles until ready/timeout
//   ST_RESP   | m_rvalid_o strobe with captured rdata/err, then back to idle
// ---------------------------------------------------------------------------
module sc_bus_ctrl
  import sc_bus_pkg::*;
#(
  parameter int                           NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int                           ADDR_W     = 32,
  parameter int                           DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = DEF_SLV_MASK,
  parameter int                           TIMEOUT    = 15
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  sc_bus_ctrl_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Last ACCESS cycle index; the counter reaches TIMEOUT on the way out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit;
  logic                  gnt;
  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_rdata;

  sc_bus_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .addr_i (bus.m_addr_i),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  assign gnt = (state_q == ST_IDLE) && bus.m_req_i;

  // Only the selected slave's ready counts; strays from others are dropped.
  assign sel_ready = |(bus.slv_ready_i & sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | bus.slv_rdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt) begin
          addr_d  = bus.m_addr_i;
          we_d    = bus.m_we_i;
          be_d    = bus.m_be_i;
          wdata_d = bus.m_wdata_i;
          sel_d   = dec_sel;
          cnt_d   = '0;
          if (dec_hit) begin
            state_d = ST_ACCESS;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // Ready is checked first so a ready in the final cycle still wins.
        if (sel_ready) begin
          rdata_d = we_q ? '0 : sel_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        cnt_d   = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.m_gnt_o     = gnt;
  assign bus.m_rvalid_o  = (state_q == ST_RESP);
  assign bus.m_rdata_o   = rdata_q;
  assign bus.m_err_o     = err_q;

  assign bus.slv_req_o   = (state_q == ST_ACCESS) ? sel_q : '0;
  assign bus.slv_we_o    = we_q;
  assign bus.slv_be_o    = be_q;
  assign bus.slv_addr_o  = addr_q;
  assign bus.slv_wdata_o = wdata_q;

endmodule

// File: tb/tb_sc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc_bus_ctrl
// Scoreboard bench for sc_bus_ctrl: the issuing side pushes the expected
// response (and the slave-side view of the access), a responder plays the
// slaves, and a monitor pops and compares on every m_rvalid_o.
// ---------------------------------------------------------------------------
module tb_sc_bus_ctrl;

  localparam int NS = 3;
  localparam int TO = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_bus_ctrl_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32)) bus ();

  sc_bus_ctrl #(
    .NUM_SLAVES (NS),
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT    (TO)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          sel;
    int          waits;
    logic [31:0] rd;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          n_req;
  } scfg_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          gcyc;
  } exp_t;

  scfg_t scfg_q[$];
  exp_t  exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rv_cyc  = -1;
  int last_gnt_cyc = -1;

  // Memory map: memory, LED bank, TTY.
  logic [31:0] mbase [NS] = '{32'h0000_0000, 32'hFF00_0000, 32'hFF00_0004};
  logic [31:0] mmask [NS] = '{32'hFF00_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & mmask[i]) == mbase[i]) return i;
    end
    return -1;
  endfunction

  // Expected response and slave view are derived from the access rules:
  // ready on wait index w gives w+1 request cycles; no ready within TO
  // cycles is an error after exactly TO request cycles.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input int waits, input logic [31:0] srd);
    int    s;
    int    n;
    bit    tmo;
    exp_t  e;
    scfg_t c;
    s = model_sel(addr);
    if (s < 0) begin
      e.rd = 32'h0; e.err = 1'b1; e.lat = 1;
    end else begin
      tmo     = (waits < 0) || (waits >= TO);
      c.sel   = s;     c.waits = waits; c.rd = srd; c.we = we;
      c.addr  = addr;  c.be    = be;    c.wd = wd;
      c.n_req = tmo ? TO : waits + 1;
      scfg_q.push_back(c);
      e.rd  = (tmo || we) ? 32'h0 : srd;
      e.err = tmo;
      e.lat = c.n_req + 1;
    end
    @(negedge clk);
    bus.m_req_i   = 1'b1;
    bus.m_we_i    = we;
    bus.m_addr_i  = addr;
    bus.m_be_i    = be;
    bus.m_wdata_i = wd;
    #1;
    n = 0;
    while (bus.m_gnt_o !== 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (bus.m_gnt_o !== 1'b1) begin
      total++; bad++;
      $display("FAIL grant_wait: actual=no grant required=grant within 200 cycles");
      scfg_q.delete();
    end else begin
      e.gcyc       = cyc;
      last_gnt_cyc = cyc;
      exp_q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic drop_req();
    @(negedge clk);
    bus.m_req_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL rvalid_wait: actual=pending %0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(bus.m_gnt_o),     32'h0);
    chk({tag, "_rvalid"}, 32'(bus.m_rvalid_o),  32'h0);
    chk({tag, "_rdata"},  bus.m_rdata_o,        32'h0);
    chk({tag, "_err"},    32'(bus.m_err_o),     32'h0);
    chk({tag, "_sreq"},   32'(bus.slv_req_o),   32'h0);
    chk({tag, "_swe"},    32'(bus.slv_we_o),    32'h0);
    chk({tag, "_sbe"},    32'(bus.slv_be_o),    32'h0);
    chk({tag, "_saddr"},  bus.slv_addr_o,       32'h0);
    chk({tag, "_swdata"}, bus.slv_wdata_o,      32'h0);
  endtask

  // Monitor: compares every response strobe against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.m_rvalid_o) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rvalid: actual=1 required=0 (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            chk("rdata",   bus.m_rdata_o,      e.rd);
            chk("err",     32'(bus.m_err_o),   32'(e.err));
            chk("latency", 32'(cyc - e.gcyc),  32'(e.lat));
            chk("gnt_in_resp", 32'(bus.m_gnt_o), 32'h0);
          end
          last_rv_cyc = cyc;
        end else begin
          chk("rdata_idle", bus.m_rdata_o,    32'h0);
          chk("err_idle",   32'(bus.m_err_o), 32'h0);
        end
      end
    end
  end

  // Slave responder: drives ready after the configured waits and checks the
  // slave-side view of each access. Non-selected slaves see random strays.
  initial begin : slave_model
    scfg_t          cur;
    bit             active;
    bit             valid;
    int             c;
    logic [NS-1:0]  rdy;
    logic [NS-1:0]  selm;
    active = 1'b0; valid = 1'b0; c = 0;
    bus.slv_ready_i = '0;
    bus.slv_rdata_i = '0;
    forever begin
      @(negedge clk);
      rdy = '0;
      if (!rst_n) begin
        active = 1'b0; valid = 1'b0;
      end else if (bus.slv_req_o != '0) begin
        if (!active) begin
          active = 1'b1; c = 0;
          if (scfg_q.size() == 0) begin
            valid = 1'b0;
            total++; bad++;
            $display("FAIL slv_req_unexpected: actual=%b required=000", bus.slv_req_o);
          end else begin
            valid = 1'b1;
            cur = scfg_q.pop_front();
            chk("slv_addr",  bus.slv_addr_o,         cur.addr);
            chk("slv_we",    32'(bus.slv_we_o),      32'(cur.we));
            chk("slv_be",    32'(bus.slv_be_o),      32'(cur.be));
            chk("slv_wdata", bus.slv_wdata_o,        cur.wd);
          end
        end
        if (valid) begin
          selm = NS'(1) << cur.sel;
          chk("slv_req", 32'(bus.slv_req_o), 32'(selm));
          rdy = NS'($urandom) & ~selm;
          if (c == cur.waits) rdy = rdy | selm;
          for (int i = 0; i < NS; i++) begin
            bus.slv_rdata_i[i*32 +: 32] = (i == cur.sel) ? cur.rd : $urandom;
          end
        end
        c++;
      end else begin
        if (active && valid) chk("slv_req_cycles", 32'(c), 32'(cur.n_req));
        active = 1'b0; valid = 1'b0;
      end
      bus.slv_ready_i = rdy;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] a;
    logic [1:0]  cat;
    int          w;
    int          r;
    bus.m_req_i   = 1'b0;
    bus.m_we_i    = 1'b0;
    bus.m_be_i    = '0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Zero-wait read from memory.
    issue(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 32'hDEAD_BEEF);
    drop_req(); wait_done();

    // Write to LED bank with three wait states.
    issue(1'b1, 32'hFF00_0000, 4'b0001, 32'h0000_00A5, 3, 32'h1234_5678);
    drop_req(); wait_done();

    // Unmapped read.
    issue(1'b0, 32'hFF00_0010, 4'hF, 32'h0, 0, 32'h0);
    drop_req(); wait_done();

    // TTY never ready: timeout.
    issue(1'b0, 32'hFF00_0004, 4'hF, 32'h0, -1, 32'hCAFE_F00D);
    drop_req(); wait_done();

    // Ready in the very last allowed cycle wins over the timeout.
    issue(1'b0, 32'hFF00_0006, 4'hF, 32'h0, TO - 1, 32'h5A5A_A5A5);
    drop_req(); wait_done();

    // Zero byte enables are forwarded unchanged.
    issue(1'b1, 32'h0000_0100, 4'b0000, 32'h8765_4321, 2, 32'hFFFF_FFFF);
    drop_req(); wait_done();

    // Reset during an LED-bank wait: access is dropped silently.
    issue(1'b1, 32'hFF00_0000, 4'b0011, 32'h0000_BEEF, 10, 32'h0);
    drop_req();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    scfg_q.delete();
    @(posedge clk); #1;
    chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(1'b0, 32'h0000_0000, 4'hF, 32'h0, 0, 32'h0BAD_F00D);
    drop_req(); wait_done();

    // Back-to-back with m_req_i held high through RESP.
    issue(1'b0, 32'h0000_0020, 4'hF, 32'h0, 1, 32'h1111_2222);
    issue(1'b0, 32'h0000_0020, 4'hF, 32'h0, 1, 32'h3333_4444);
    chk("b2b_gnt_cycle", 32'(last_gnt_cyc), 32'(last_rv_cyc + 1));
    drop_req(); wait_done();

    // Randomised traffic over all regions, unmapped space and timeouts.
    for (int k = 0; k < 60; k++) begin
      cat = 2'($urandom_range(0, 3));
      case (cat)
        2'd0:    a = {8'h00, 24'($urandom)};
        2'd1:    a = 32'hFF00_0000 | ($urandom & 32'h3);
        2'd2:    a = 32'hFF00_0004 | ($urandom & 32'h3);
        default: a = ($urandom_range(0, 1) == 0) ? (32'hFF00_0008 + ($urandom & 32'h00FF_FFF0))
                                                  : {8'($urandom_range(1, 254)), 24'($urandom)};
      endcase
      r = $urandom_range(0, 9);
      if (r < 7)       w = $urandom_range(0, 4);
      else if (r == 7) w = TO - 1;
      else if (r == 8) w = TO;
      else             w = -1;
      issue(1'($urandom), a, 4'($urandom), $urandom, w, $urandom);
      drop_req(); wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
